// File: rtl/sar_compare_driver_pkg.sv
// sar_compare_driver_pkg: shared state encoding and comparator verdict helpers.
package sar_pkg;
  typedef enum logic [1:0] {IDLE, PROBE, VERIFY, DONE} state_t;
  localparam logic [2:0] V_AISBIG = 3'b100;
  localparam logic [2:0] V_BISBIG = 3'b010;
  localparam logic [2:0] V_EQUAL  = 3'b001;
  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == V_AISBIG) || (v == V_BISBIG) || (v == V_EQUAL);
  endfunction
endpackage

// File: rtl/sar_compare_driver_if.sv
// sar_compare_driver_if: trial operand out to the comparator, verdict back.
interface sar_compare_driver_if #(parameter int N = 4);
  logic [N-1:0] trial;
  logic cmp_enable;
  logic cmp_aisbig;
  logic cmp_bisbig;
  logic cmp_equal;
  modport master(output trial, cmp_enable, input cmp_aisbig, cmp_bisbig, cmp_equal);
  modport slave(input trial, cmp_enable, output cmp_aisbig, cmp_bisbig, cmp_equal);
endinterface

// File: rtl/sar_compare_driver.sv
// sar_compare_driver: MSB-first successive-approximation search through a magnitude comparator.
module sar_compare_driver
  import sar_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  sar_compare_driver_if.master cmp,
  output logic                busy,
  output logic                done,
  output logic [N-1:0]        result,
  output logic                found,
  output logic                error
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  state_t state, state_nx;
  logic [N-1:0] trial, trial_nx, result_nx;
  logic [IW-1:0] idx, idx_nx;
  logic found_nx, error_nx;
  logic [2:0] v;
  assign v = {cmp.cmp_aisbig, cmp.cmp_bisbig, cmp.cmp_equal};
  assign cmp.trial = trial;
  assign cmp.cmp_enable = (state == PROBE) || (state == VERIFY);
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      trial  <= '0;
      idx    <= '0;
      result <= '0;
      found  <= 1'b0;
      error  <= 1'b0;
    end else begin
      state  <= state_nx;
      trial  <= trial_nx;
      idx    <= idx_nx;
      result <= result_nx;
      found  <= found_nx;
      error  <= error_nx;
    end
  end
  always_comb begin
    state_nx  = state;
    trial_nx  = trial;
    idx_nx    = idx;
    result_nx = result;
    found_nx  = found;
    error_nx  = error;
    case (state)
      IDLE: if (start) begin
        trial_nx        = '0;
        trial_nx[N-1]   = 1'b1;
        idx_nx          = IW'(N - 1);
        result_nx       = '0;
        found_nx        = 1'b0;
        error_nx        = 1'b0;
        state_nx        = PROBE;
      end
      PROBE: if (!is_onehot3(v)) begin
        error_nx  = 1'b1;
        result_nx = trial;
        found_nx  = 1'b0;
        state_nx  = DONE;
      end else if (v == V_EQUAL) begin
        result_nx = trial;
        found_nx  = 1'b1;
        state_nx  = DONE;
      end else begin
        if (v == V_AISBIG) trial_nx[idx] = 1'b0;
        if (idx == '0) state_nx = VERIFY;
        else begin
          idx_nx = idx - 1'b1;
          trial_nx[idx - 1'b1] = 1'b1;
        end
      end
      VERIFY: begin
        result_nx = trial;
        found_nx  = cmp.cmp_equal;
        state_nx  = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule
